// File: rtl/sl811_host_bus.sv
// SL811 host bus master: each access is an address write (A0=0) then a data read/write (A0=1).
// Optional macro SL811_AUTOINC_EN skips the address phase when the chip's autoincrement already points at addr.
module sl811_host_bus #(
    parameter int T_SU  = 1,
    parameter int T_STB = 3,
    parameter int T_REC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rnw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       sl_a0,
    output logic       sl_cs_n,
    output logic       sl_rd_n,
    output logic       sl_wr_n,
    output logic [7:0] sl_d_out,
    output logic       sl_d_oe,
    input  logic [7:0] sl_d_in,
    input  logic       sl_intrq,
    output logic       intrq
);

    typedef enum logic [2:0] {
        IDLE,
        A_SU,
        A_STB,
        A_REC,
        D_SU,
        D_STB,
        D_REC
    } state_t;

    localparam logic [3:0] SU_LD  = 4'(T_SU - 1);
    localparam logic [3:0] STB_LD = 4'(T_STB - 1);
    localparam logic [3:0] REC_LD = 4'(T_REC - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       rnw_reg;
    logic [7:0] addr_reg, wdata_reg;
    logic       busy_reg, ack_reg, a0_reg, cs_n_reg, rd_n_reg, wr_n_reg, d_oe_reg;
    logic [7:0] rdata_reg, d_out_reg;
    logic [1:0] sync_reg;

    logic       busy_next, ack_next, a0_next, cs_n_next, rd_n_next, wr_n_next, d_oe_next;
    logic [7:0] d_out_next;
    logic       last, capture, data_done, first_rec, hit;
    logic       rnw_cur;
    logic [7:0] addr_cur, wdata_cur;

    assign last      = (cnt_reg == 4'd0);
    assign capture   = (state_reg == IDLE) && req;
    assign data_done = (state_reg == D_REC) && last;

    // Outputs are registered from the next state, so the request fields must
    // come straight from the inputs on the accepting edge.
    assign rnw_cur   = (state_reg == IDLE) ? rnw   : rnw_reg;
    assign addr_cur  = (state_reg == IDLE) ? addr  : addr_reg;
    assign wdata_cur = (state_reg == IDLE) ? wdata : wdata_reg;

`ifdef SL811_AUTOINC_EN
    logic [7:0] next_addr_reg;
    logic       next_valid_reg;

    assign hit = next_valid_reg && (addr == next_addr_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr_reg  <= 8'h00;
            next_valid_reg <= 1'b0;
        end else if (data_done) begin
            next_addr_reg  <= addr_reg + 8'd1;
            next_valid_reg <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = last ? cnt_reg : cnt_reg - 4'd1;
        ack_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = cnt_reg;
                if (req) begin
                    state_next = hit ? D_SU : A_SU;
                    cnt_next   = SU_LD;
                end
            end
            A_SU:  if (last) begin state_next = A_STB; cnt_next = STB_LD; end
            A_STB: if (last) begin state_next = A_REC; cnt_next = REC_LD; end
            A_REC: if (last) begin state_next = D_SU;  cnt_next = SU_LD;  end
            D_SU:  if (last) begin state_next = D_STB; cnt_next = STB_LD; end
            D_STB: if (last) begin state_next = D_REC; cnt_next = REC_LD; end
            D_REC: if (last) begin state_next = IDLE; cnt_next = 4'd0; ack_next = 1'b1; end
            default: begin state_next = IDLE; cnt_next = 4'd0; end
        endcase
    end

    always_comb begin
        busy_next  = (state_next != IDLE);
        cs_n_next  = !(state_next inside {A_SU, A_STB, D_SU, D_STB});
        a0_next    = (state_next inside {D_SU, D_STB, D_REC});
        wr_n_next  = !((state_next == A_STB) || ((state_next == D_STB) && !rnw_cur));
        rd_n_next  = !((state_next == D_STB) && rnw_cur);
        // Data stays driven one cycle past the write strobe for hold time.
        first_rec  = ((state_next == A_REC) && (state_reg == A_STB)) ||
                     ((state_next == D_REC) && (state_reg == D_STB));
        d_oe_next  = (state_next inside {A_SU, A_STB}) ||
                     ((state_next == A_REC) && first_rec) ||
                     (!rnw_cur && ((state_next inside {D_SU, D_STB}) ||
                                   ((state_next == D_REC) && first_rec)));
        d_out_next = d_out_reg;
        if (state_next inside {A_SU, A_STB, A_REC})
            d_out_next = addr_cur;
        else if ((state_next inside {D_SU, D_STB, D_REC}) && !rnw_cur)
            d_out_next = wdata_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rnw_reg   <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            busy_reg  <= 1'b0;
            ack_reg   <= 1'b0;
            rdata_reg <= 8'h00;
            a0_reg    <= 1'b0;
            cs_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
            wr_n_reg  <= 1'b1;
            d_out_reg <= 8'h00;
            d_oe_reg  <= 1'b0;
            sync_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                rnw_reg   <= rnw;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            busy_reg  <= busy_next;
            ack_reg   <= ack_next;
            if ((state_reg == D_STB) && last && rnw_reg)
                rdata_reg <= sl_d_in;
            a0_reg    <= a0_next;
            cs_n_reg  <= cs_n_next;
            rd_n_reg  <= rd_n_next;
            wr_n_reg  <= wr_n_next;
            d_out_reg <= d_out_next;
            d_oe_reg  <= d_oe_next;
            sync_reg  <= {sync_reg[0], sl_intrq};
        end
    end

    assign busy     = busy_reg;
    assign ack      = ack_reg;
    assign rdata    = rdata_reg;
    assign sl_a0    = a0_reg;
    assign sl_cs_n  = cs_n_reg;
    assign sl_rd_n  = rd_n_reg;
    assign sl_wr_n  = wr_n_reg;
    assign sl_d_out = d_out_reg;
    assign sl_d_oe  = d_oe_reg;
    assign intrq    = sync_reg[1];

endmodule

// File: tb/tb_sl811_host_bus.sv
// Bench for sl811_host_bus: SL811 register-file model on the pins, transaction-level reference model.
// Define SL811_AUTOINC_EN for both bench and RTL to exercise the autoincrement path.
module tb_sl811_host_bus;

`ifdef SL811_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int FULL_LAT = 2 * (1 + 3 + 2);
    localparam int HALF_LAT = 1 + 3 + 2;

    logic       clk = 1'b0;
    logic       rst, req, rnw, sl_intrq;
    logic [7:0] addr, wdata;
    logic       busy, ack, sl_a0, sl_cs_n, sl_rd_n, sl_wr_n, sl_d_oe, intrq;
    logic [7:0] rdata, sl_d_out, sl_d_in;

    sl811_host_bus dut (
        .clk(clk), .rst(rst), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .sl_a0(sl_a0), .sl_cs_n(sl_cs_n),
        .sl_rd_n(sl_rd_n), .sl_wr_n(sl_wr_n), .sl_d_out(sl_d_out), .sl_d_oe(sl_d_oe),
        .sl_d_in(sl_d_in), .sl_intrq(sl_intrq), .intrq(intrq)
    );

    always #5 clk = ~clk;

    // SL811 chip model: address register loaded by A0=0 writes, post-increment on each data access.
    logic       model_init;
    logic [7:0] chip_mem [256];
    logic [7:0] ptr, wlat, d_drv;
    logic       wpend, rpend;
    int         overlap = 0;

    assign sl_d_in = d_drv;

    always @(negedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 256; i++) chip_mem[i] <= 8'(i) ^ 8'h32;
            ptr   <= 8'h00;
            wlat  <= 8'h00;
            d_drv <= 8'h00;
            wpend <= 1'b0;
            rpend <= 1'b0;
        end else begin
            if (!sl_wr_n && !sl_cs_n) begin
                if (!sl_a0) ptr <= sl_d_out;
                else begin wlat <= sl_d_out; wpend <= 1'b1; end
            end
            if (!sl_rd_n && !sl_cs_n && sl_a0) begin
                d_drv <= chip_mem[ptr];
                rpend <= 1'b1;
            end
            if (sl_wr_n && wpend) begin
                chip_mem[ptr] <= wlat;
                ptr   <= ptr + 8'd1;
                wpend <= 1'b0;
            end
            if (sl_rd_n && rpend) begin
                ptr   <= ptr + 8'd1;
                rpend <= 1'b0;
            end
        end
        if (!sl_rd_n && !sl_wr_n) overlap <= overlap + 1;
    end

    // Transaction-level reference: register contents plus "last completed address + 1".
    logic [7:0] ref_mem [256];
    logic [7:0] ref_next;
    logic       ref_valid;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_hit(input logic [7:0] a);
        return AUTOINC && ref_valid && (a == ref_next);
    endfunction

    task automatic access(input logic r, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input logic use_exp);
        int         lat, astb, dstb, bad;
        logic       cs0, busy0, hit;
        logic [7:0] want;
        hit = ref_hit(a);
        @(negedge clk);
        req = 1'b1; rnw = r; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        cs0 = sl_cs_n; busy0 = busy;
        lat = 0; astb = 0; dstb = 0; bad = 0;
        while (!ack && lat < 100) begin
            if (!sl_cs_n && !sl_wr_n && !sl_a0) begin
                astb++;
                if (sl_d_out != a) bad++;
            end
            if (!sl_cs_n && sl_a0 && (r ? !sl_rd_n : !sl_wr_n)) begin
                dstb++;
                if (!r && sl_d_out != d) bad++;
            end
            if (r && sl_a0 && sl_d_oe) bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk("ack_latency", 32'(lat), 32'(hit ? HALF_LAT : FULL_LAT));
        chk("cs_fall_at_e0", 32'(cs0), 32'd0);
        chk("busy_after_accept", 32'(busy0), 32'd1);
        chk("addr_strobe_cycles", 32'(astb), 32'(hit ? 0 : 3));
        chk("data_strobe_cycles", 32'(dstb), 32'd3);
        chk("bus_value_errors", 32'(bad), 32'd0);
        chk("busy_at_ack", 32'(busy), 32'd0);
        if (r) begin
            want = use_exp ? exp_rd : ref_mem[a];
            chk("read_data", 32'(rdata), 32'(want));
        end else begin
            ref_mem[a] = d;
            chk("chip_write", 32'(chip_mem[a]), 32'(d));
        end
        ref_valid = 1'b1;
        ref_next  = a + 8'd1;
        $display("txn %s addr=%02h data=%02h lat=%0d rdata=%02h", r ? "RD" : "WR", a, d, lat, rdata);
    endtask

    typedef struct {
        logic       r;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int         n, bsy;
        logic [7:0] last_a, ra;

        tbl[0] = '{1'b0, 8'h05, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 8'h0E, 8'h00, 8'h3C};
        tbl[2] = '{1'b1, 8'h05, 8'h00, 8'hA5};
        tbl[3] = '{1'b0, 8'h80, 8'h5A, 8'h00};
        tbl[4] = '{1'b1, 8'h80, 8'h00, 8'h5A};
        tbl[5] = '{1'b0, 8'hFF, 8'h01, 8'h00};
        tbl[6] = '{1'b1, 8'h10, 8'h00, 8'h22};
        tbl[7] = '{1'b0, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h32;
        ref_valid = 1'b0; ref_next = 8'h00;

        rst = 1'b1; model_init = 1'b1; req = 1'b0; rnw = 1'b0;
        addr = 8'h00; wdata = 8'h00; sl_intrq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({busy, ack, rdata, sl_a0, sl_cs_n, sl_rd_n, sl_wr_n, sl_d_out, sl_d_oe, intrq}),
            32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0; model_init = 1'b0;

        // Interrupt synchroniser: two edges of latency in both directions.
        @(negedge clk); sl_intrq = 1'b1;
        @(posedge clk); #1; chk("intrq_rise_edge1", 32'(intrq), 32'd0);
        @(posedge clk); #1; chk("intrq_rise_edge2", 32'(intrq), 32'd1);
        @(negedge clk); sl_intrq = 1'b0;
        @(posedge clk); #1; chk("intrq_fall_edge1", 32'(intrq), 32'd1);
        @(posedge clk); #1; chk("intrq_fall_edge2", 32'(intrq), 32'd0);

        for (int i = 0; i < 8; i++)
            access(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_rd, 1'b1);

        // Back-to-back: req held across the first access, second accepted in the ack cycle.
        @(negedge clk);
        req = 1'b1; rnw = 1'b0; addr = 8'h30; wdata = 8'h11;
        @(posedge clk); #1;
        addr = 8'h50; wdata = 8'h22;
        n = 0;
        while (!ack && n < 100) begin @(posedge clk); #1; n++; end
        chk("b2b_first_latency", 32'(n), 32'(ref_hit(8'h30) ? HALF_LAT : FULL_LAT));
        ref_mem[8'h30] = 8'h11; ref_valid = 1'b1; ref_next = 8'h31;
        @(posedge clk); #1;
        chk("b2b_second_cs_fall", 32'(sl_cs_n), 32'd0);
        chk("b2b_second_busy", 32'(busy), 32'd1);
        req = 1'b0;
        n = 0;
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1; n++;
        @(negedge clk); req = 1'b0;
        while (!ack && n < 100) begin @(posedge clk); #1; n++; end
        chk("b2b_second_latency", 32'(n), 32'(ref_hit(8'h50) ? HALF_LAT : FULL_LAT));
        ref_mem[8'h50] = 8'h22; ref_valid = 1'b1; ref_next = 8'h51;
        $display("txn b2b WR 30:=11, WR 50:=22");
        chk("b2b_chip_30", 32'(chip_mem[8'h30]), 32'h11);
        chk("b2b_chip_50", 32'(chip_mem[8'h50]), 32'h22);
        bsy = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (busy || !sl_cs_n) bsy++;
        end
        chk("busy_req_ignored", 32'(bsy), 32'd0);

        // Reset during the address strobe, then the next access must not skip its address phase.
        access(1'b0, 8'h60, 8'h66, 8'h00, 1'b0);
        @(negedge clk);
        req = 1'b1; rnw = 1'b0; addr = 8'h70; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!(!sl_wr_n && !sl_a0) && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_reach_addr_strobe", 32'(n < 20), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_access_pins", 32'({sl_wr_n, sl_rd_n, sl_cs_n, busy, ack, sl_d_oe}), 32'(6'b111000));
        @(negedge clk); rst = 1'b0;
        ref_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_ack", 32'(ack), 32'd0);
        $display("txn reset during address strobe of WR 70");
        access(1'b0, 8'h61, 8'h6A, 8'h00, 1'b0);

`ifdef SL811_AUTOINC_EN
        access(1'b0, 8'hFE, 8'hE1, 8'h00, 1'b0);
        access(1'b0, 8'hFF, 8'hE2, 8'h00, 1'b0);
        access(1'b0, 8'h00, 8'hE3, 8'h00, 1'b0);
        access(1'b0, 8'h05, 8'hE4, 8'h00, 1'b0);
`endif

        // Randomized accesses, biased towards sequential addresses.
        last_a = 8'h05;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? last_a + 8'd1 : 8'($urandom);
            access(1'($urandom_range(0, 1)), ra, 8'($urandom), 8'h00, 1'b0);
            last_a = ra;
        end

        chk("strobe_overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
